// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths and constants for the RV32I pipeline
package riscv_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter register with reset priority and load enable
module pc_reg import riscv_pkg::*; #(
   parameter int W = XLEN,
   parameter logic [W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] pc
);
   // reset first, otherwise load the selected next PC when enabled
   always_ff @(posedge clk)
      if (rst) pc <= RESET_VECTOR;
      else if (en) pc <= d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC selection and F/D pipeline register of the RV32I core
module fetch_stage import riscv_pkg::*; #(
   parameter int DATA_WIDTH = XLEN,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  StallF,
   input  logic                  StallD,
   input  logic                  FlushD,
   input  logic                  PCSrcE,
   input  logic [DATA_WIDTH-1:0] PCTargetE,
   input  logic [DATA_WIDTH-1:0] InstrF,
   output logic [DATA_WIDTH-1:0] PCF,
   output logic [DATA_WIDTH-1:0] InstrD,
   output logic [DATA_WIDTH-1:0] PCD,
   output logic [DATA_WIDTH-1:0] PCPlus4D,
   output logic                  ValidD
);
   logic [DATA_WIDTH-1:0] pc_plus4, pc_next;
   // one +4 adder feeds both the sequential PC and PCPlus4D; redirect target is word aligned
   always_comb begin
      pc_plus4 = PCF + DATA_WIDTH'(4);
      pc_next  = PCSrcE ? {PCTargetE[DATA_WIDTH-1:2], 2'b00} : pc_plus4;
   end
   pc_reg #(.W(DATA_WIDTH), .RESET_VECTOR(RESET_VECTOR)) u_pc (
      .clk(clk),
      .rst(rst),
      .en(PCSrcE | ~StallF),
      .d(pc_next),
      .pc(PCF)
   );
   // F/D register: reset and flush insert a bubble, flush beats stall
   always_ff @(posedge clk)
      if (rst || FlushD) begin
         InstrD   <= DATA_WIDTH'(NOP_INSTR);
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (!StallD) begin
         InstrD   <= InstrF;
         PCD      <= PCF;
         PCPlus4D <= pc_plus4;
         ValidD   <= 1'b1;
      end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus expected-value queue for fetch_stage
module tb_fetch_stage;
   typedef struct {
      logic        rst, sf, sd, fd, ps;
      logic [31:0] tgt, pcf, instr, pcd, pc4;
      logic        v;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, StallF, StallD, FlushD, PCSrcE, ValidD;
   logic [31:0] PCTargetE, InstrF, PCF, InstrD, PCD, PCPlus4D;
   int errors = 0;
   int checks = 0;
   vec_t tbl[16];
   vec_t sb[$];
   vec_t e;
   logic [31:0] prev_pcf;

   fetch_stage dut (
      .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF), .PCF(PCF),
      .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
   );

   assign InstrF = {PCF[26:0], 5'b0} | 32'h33;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", name, i, act, exp);
      end
   endtask

   initial begin
      //          rst  sf   sd   fd   ps   tgt           pcf           instr         pcd           pc4           v
      tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h13,       32'h0,        32'h0,        1'b0};
      tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h4,        32'h33,       32'h0,        32'h4,        1'b1};
      tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h8,        32'hB3,       32'h4,        32'h8,        1'b1};
      tbl[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h8,        32'hB3,       32'h4,        32'h8,        1'b1};
      tbl[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h8,        32'hB3,       32'h4,        32'h8,        1'b1};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'hC,        32'h133,      32'h8,        32'hC,        1'b1};
      tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,32'h40,       32'h40,       32'h13,       32'h0,        32'h0,        1'b0};
      tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h44,       32'h833,      32'h40,       32'h44,       1'b1};
      tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,32'h22,       32'h20,       32'h8B3,      32'h44,       32'h48,       1'b1};
      tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        32'h24,       32'h13,       32'h0,        32'h0,        1'b0};
      tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h24,       32'h4B3,      32'h24,       32'h28,       1'b1};
      tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'hFFFFFFFF, 32'hFFFFFFFC, 32'h4B3,      32'h24,       32'h28,       1'b1};
      tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'hFFFFFFB3, 32'hFFFFFFFC, 32'h0,        1'b1};
      tbl[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'hFFFFFFFC, 32'hFFFFFFFC, 32'h33,       32'h0,        32'h4,        1'b1};
      tbl[14] = '{1'b1,1'b1,1'b1,1'b0,1'b1,32'h80,       32'h0,        32'h13,       32'h0,        32'h0,        1'b0};
      tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h4,        32'h33,       32'h0,        32'h4,        1'b1};
      {rst, StallF, StallD, FlushD, PCSrcE, PCTargetE} = '0;
      prev_pcf = '0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         rst = tbl[i].rst; StallF = tbl[i].sf; StallD = tbl[i].sd;
         FlushD = tbl[i].fd; PCSrcE = tbl[i].ps; PCTargetE = tbl[i].tgt;
         sb.push_back(tbl[i]);
         #1;
         if (i > 0) chk("PCF_hold", i, PCF, prev_pcf);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         prev_pcf = e.pcf;
         chk("PCF", i, PCF, e.pcf);
         chk("InstrD", i, InstrD, e.instr);
         chk("PCD", i, PCD, e.pcd);
         chk("PCPlus4D", i, PCPlus4D, e.pc4);
         chk("ValidD", i, {31'b0, ValidD}, {31'b0, e.v});
      end
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
